// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: access size codes, FSM state
// encoding and the lane/byte-enable helpers used by the top and load_extend.
package mem_stage_pkg;

    // RV32 funct3 size/sign codes. Stores reuse the load encodings.
    localparam logic [2:0] DM_LB  = 3'b000;
    localparam logic [2:0] DM_LH  = 3'b001;
    localparam logic [2:0] DM_LW  = 3'b010;
    localparam logic [2:0] DM_LBU = 3'b100;
    localparam logic [2:0] DM_LHU = 3'b101;
    localparam logic [2:0] DM_SB  = 3'b000;
    localparam logic [2:0] DM_SH  = 3'b001;
    localparam logic [2:0] DM_SW  = 3'b010;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Decode the access width; any code without a defined meaning is a word.
    function automatic size_e access_size(input logic [2:0] dmtype, input logic is_store);
        size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (dmtype)
                DM_SB:   sz = SZ_BYTE;
                DM_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (dmtype)
                DM_LB, DM_LBU: sz = SZ_BYTE;
                DM_LH, DM_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    // Lane actually used: misaligned low bits are dropped to the natural boundary.
    function automatic logic [1:0] effective_lane(input size_e sz, input logic [1:0] lo);
        logic [1:0] lane;
        case (sz)
            SZ_BYTE: lane = lo;
            SZ_HALF: lane = {lo[1], 1'b0};
            default: lane = 2'b00;
        endcase
        return lane;
    endfunction

    // True when the address is not naturally aligned for the access width.
    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        logic mis;
        case (sz)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            default: mis = |lo;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] lane);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data copied into every lane so the byte enables pick the right one.
    function automatic logic [31:0] replicate(input size_e sz, input logic [31:0] data);
        logic [31:0] rep;
        case (sz)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute, data-memory and writeback signals of the memory stage.
// MEM_MISALIGN_TRAP_EN adds the mem_exc writeback flag.
interface mem_stage_if;

    logic        ex_valid;
    logic [31:0] ex_c;
    logic [31:0] ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_rwe;
    logic        ex_mrd;
    logic        ex_mwr;
    logic [2:0]  ex_dmtype;
    logic        ex_ready;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mem_exc;
`endif

    // Memory stage side.
    modport slave (
        input  ex_valid, ex_c, ex_rs2, ex_rd, ex_rwe, ex_mrd, ex_mwr, ex_dmtype,
        input  dm_rdata, dm_ack,
        output ex_ready,
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output wb_valid, wb_rd, wb_we, wb_data
`ifdef MEM_MISALIGN_TRAP_EN
        , output mem_exc
`endif
    );

    // Pipeline / memory environment side.
    modport master (
        output ex_valid, ex_c, ex_rs2, ex_rd, ex_rwe, ex_mrd, ex_mwr, ex_dmtype,
        output dm_rdata, dm_ack,
        input  ex_ready,
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  wb_valid, wb_rd, wb_we, wb_data
`ifdef MEM_MISALIGN_TRAP_EN
        , input mem_exc
`endif
    );

endinterface

// File: rtl/mem_stage_load_extend.sv
// Load lane select and sign/zero extension of the data-memory read word.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_dmtype,
    output logic [31:0] o_data
);

    logic [7:0]  w_bytes  [0:3];
    logic [15:0] w_halves [0:1];
    size_e       w_size;
    logic        w_unsigned;
    logic [7:0]  w_byte_sel;
    logic [15:0] w_half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign w_bytes[gi] = i_rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_halves
            assign w_halves[gi] = i_rdata[16*gi +: 16];
        end
    endgenerate

    assign w_size     = access_size(i_dmtype, 1'b0);
    assign w_unsigned = i_dmtype[2];
    assign w_byte_sel = w_bytes[i_lane];
    assign w_half_sel = w_halves[i_lane[1]];

    // Pick the addressed lane and extend it to 32 bits.
    always_comb begin
        o_data = i_rdata;
        case (w_size)
            SZ_BYTE: o_data = w_unsigned ? {24'd0, w_byte_sel} : {{24{w_byte_sel[7]}}, w_byte_sel};
            SZ_HALF: o_data = w_unsigned ? {16'd0, w_half_sel} : {{16{w_half_sel[15]}}, w_half_sel};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory stage: passes ALU results through in one cycle and runs loads
// and stores as a req/ack transaction on the data-memory port.
// MEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise mem_exc instead
// of being silently aligned.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);

    state_e      r_state;
    state_e      w_state_next;
    logic        w_ex_ready;
    logic        w_dm_req;

    // Access latched on acceptance and held for the whole WAIT.
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_lane;
    logic [2:0]  r_dmtype;
    logic [4:0]  r_rd;
    logic        r_rwe;

    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic        r_wb_we;
    logic [31:0] r_wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        r_mem_exc;
`endif

    logic        w_is_mem;
    logic        w_is_store;
    size_e       w_size;
    logic [1:0]  w_lane;
    logic        w_trap;
    logic [31:0] w_load_data;

    // A request with both load and store set is treated as a store.
    assign w_is_mem   = bus.ex_mrd | bus.ex_mwr;
    assign w_is_store = bus.ex_mwr;
    assign w_size     = access_size(bus.ex_dmtype, w_is_store);
    assign w_lane     = effective_lane(w_size, bus.ex_c[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_is_mem & misaligned(w_size, bus.ex_c[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_ex_ready   = 1'b0;
        w_dm_req     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ex_ready = 1'b1;
                if (bus.ex_valid && w_is_mem && !w_trap) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_dm_req = 1'b1;
                if (bus.dm_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture address, enables and store data when an access is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_be     <= 4'd0;
            r_wdata  <= 32'd0;
            r_lane   <= 2'd0;
            r_dmtype <= 3'd0;
            r_rd     <= 5'd0;
            r_rwe    <= 1'b0;
        end else if (r_state == ST_IDLE && bus.ex_valid && w_is_mem && !w_trap) begin
            r_we     <= w_is_store;
            r_addr   <= {bus.ex_c[31:2], 2'b00};
            r_be     <= lane_mask(w_size, w_lane);
            r_wdata  <= replicate(w_size, bus.ex_rs2);
            r_lane   <= w_lane;
            r_dmtype <= bus.ex_dmtype;
            r_rd     <= bus.ex_rd;
            r_rwe    <= bus.ex_rwe;
        end
    end

    load_extend u_load_extend (
        .i_rdata  (bus.dm_rdata),
        .i_lane   (r_lane),
        .i_dmtype (r_dmtype),
        .o_data   (w_load_data)
    );

    // Writeback register: one-cycle pulse per completed instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_we    <= 1'b0;
            r_wb_data  <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_mem_exc  <= 1'b0;
`endif
        end else begin
            r_wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_mem_exc  <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (bus.ex_valid && !w_is_mem) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= bus.ex_rd;
                        r_wb_we    <= bus.ex_rwe;
                        r_wb_data  <= bus.ex_c;
                    end else if (bus.ex_valid && w_trap) begin
                        // Faulting address is reported on wb_data.
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= bus.ex_rd;
                        r_wb_we    <= 1'b0;
                        r_wb_data  <= bus.ex_c;
`ifdef MEM_MISALIGN_TRAP_EN
                        r_mem_exc  <= 1'b1;
`endif
                    end
                end
                ST_WAIT: begin
                    if (bus.dm_ack) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        if (r_we) begin
                            r_wb_we   <= 1'b0;
                            r_wb_data <= 32'd0;
                        end else begin
                            r_wb_we   <= r_rwe;
                            r_wb_data <= w_load_data;
                        end
                    end
                end
                default: r_wb_valid <= 1'b0;
            endcase
        end
    end

    assign bus.ex_ready = w_ex_ready;
    assign bus.dm_req   = w_dm_req;
    assign bus.dm_we    = r_we;
    assign bus.dm_addr  = r_addr;
    assign bus.dm_be    = r_be;
    assign bus.dm_wdata = r_wdata;
    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_rd    = r_wb_rd;
    assign bus.wb_we    = r_wb_we;
    assign bus.wb_data  = r_wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    assign bus.mem_exc  = r_mem_exc;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard.
module tb_mem_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        chk_data;
        logic        exc;
    } wb_exp_t;

    wb_exp_t sb_q[$];

    mem_stage_if u_if ();

    mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample just after the edge, and score any writeback.
    task automatic step();
        wb_exp_t e;
        @(posedge clk);
        #1;
        if (u_if.wb_valid === 1'b1) begin
            check("wb_expected", (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("wb_rd", {27'd0, u_if.wb_rd}, {27'd0, e.rd});
                check("wb_we", {31'd0, u_if.wb_we}, {31'd0, e.we});
                if (e.chk_data) check("wb_data", u_if.wb_data, e.data);
`ifdef MEM_MISALIGN_TRAP_EN
                check("mem_exc", {31'd0, u_if.mem_exc}, {31'd0, e.exc});
`endif
            end
        end
    endtask

    task automatic drive_ex(input logic valid, input logic [31:0] c, input logic [31:0] rs2,
                            input logic [4:0] rd, input logic rwe, input logic mrd,
                            input logic mwr, input logic [2:0] dmtype);
        u_if.ex_valid  = valid;
        u_if.ex_c      = c;
        u_if.ex_rs2    = rs2;
        u_if.ex_rd     = rd;
        u_if.ex_rwe    = rwe;
        u_if.ex_mrd    = mrd;
        u_if.ex_mwr    = mwr;
        u_if.ex_dmtype = dmtype;
    endtask

    task automatic alu_op(input string tag, input logic [31:0] c, input logic [4:0] rd, input logic rwe);
        drive_ex(1'b1, c, 32'h0, rd, rwe, 1'b0, 1'b0, 3'b000);
        sb_q.push_back('{rd: rd, we: rwe, data: c, chk_data: 1'b1, exc: 1'b0});
        step();
        check({tag, "_wb_valid"}, {31'd0, u_if.wb_valid}, 32'd1);
        check({tag, "_dm_req"}, {31'd0, u_if.dm_req}, 32'd0);
        check({tag, "_ex_ready"}, {31'd0, u_if.ex_ready}, 32'd1);
    endtask

    // One memory access held for waits+1 request cycles, acked on the last.
    task automatic mem_op(input string tag, input logic [31:0] c, input logic [31:0] rs2,
                          input logic [31:0] rdata, input logic mrd, input logic mwr,
                          input logic [2:0] dmtype, input logic [4:0] rd, input int waits,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_wb_data);
        int req_cycles;
        logic [31:0] exp_addr;
        exp_addr = {c[31:2], 2'b00};
        req_cycles = 0;
        drive_ex(1'b1, c, rs2, rd, 1'b1, mrd, mwr, dmtype);
        sb_q.push_back('{rd: rd, we: !mwr, data: exp_wb_data, chk_data: 1'b1, exc: 1'b0});
        u_if.dm_rdata = 32'hDEAD_BEEF;
        step();
        for (int i = 0; i <= waits; i++) begin
            check({tag, "_ex_ready"}, {31'd0, u_if.ex_ready}, 32'd0);
            check({tag, "_dm_addr"}, u_if.dm_addr, exp_addr);
            check({tag, "_dm_we"}, {31'd0, u_if.dm_we}, {31'd0, mwr});
            check({tag, "_wb_valid_wait"}, {31'd0, u_if.wb_valid}, 32'd0);
            if (mwr) begin
                check({tag, "_dm_be"}, {28'd0, u_if.dm_be}, {28'd0, exp_be});
                check({tag, "_dm_wdata"}, u_if.dm_wdata, exp_wdata);
            end
            if (u_if.dm_req === 1'b1) req_cycles++;
            if (i == waits) begin
                u_if.dm_ack   = 1'b1;
                u_if.dm_rdata = rdata;
            end
            step();
        end
        u_if.dm_ack   = 1'b0;
        u_if.ex_valid = 1'b0;
        check({tag, "_req_cycles"}, req_cycles, waits + 1);
        check({tag, "_done_valid"}, {31'd0, u_if.wb_valid}, 32'd1);
        check({tag, "_done_req"}, {31'd0, u_if.dm_req}, 32'd0);
        check({tag, "_sb_drained"}, sb_q.size(), 0);
        step();
        check({tag, "_after_valid"}, {31'd0, u_if.wb_valid}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        u_if.dm_rdata = 32'h0;
        u_if.dm_ack   = 1'b0;
        step();
        step();
        check("rst_dm_req", {31'd0, u_if.dm_req}, 32'd0);
        check("rst_wb_valid", {31'd0, u_if.wb_valid}, 32'd0);
        check("rst_wb_we", {31'd0, u_if.wb_we}, 32'd0);
        check("rst_wb_data", u_if.wb_data, 32'd0);
        check("rst_wb_rd", {27'd0, u_if.wb_rd}, 32'd0);
        check("rst_ex_ready", {31'd0, u_if.ex_ready}, 32'd1);
        rst = 1'b0;
        step();

        // Pass-through ALU results, including back-to-back and rwe=0.
        alu_op("alu1", 32'h0000_1234, 5'd5, 1'b1);
        alu_op("alu2", 32'hFFFF_0000, 5'd31, 1'b0);
        u_if.ex_valid = 1'b0;
        step();
        check("bubble_wb_valid", {31'd0, u_if.wb_valid}, 32'd0);

        // dm_ack in IDLE has no effect.
        u_if.dm_ack = 1'b1;
        step();
        u_if.dm_ack = 1'b0;
        check("idle_ack_wb_valid", {31'd0, u_if.wb_valid}, 32'd0);
        check("idle_ack_dm_req", {31'd0, u_if.dm_req}, 32'd0);

        //      tag       c             rs2           rdata         mrd   mwr   type    rd    w  be       wdata          wb_data
        mem_op("lb",     32'h103, 32'h0,        32'h80FF_0000, 1'b1, 1'b0, 3'b000, 5'd7, 2, 4'h0, 32'h0,         32'hFFFF_FF80);
        mem_op("lhu",    32'h102, 32'h0,        32'h8001_0000, 1'b1, 1'b0, 3'b101, 5'd8, 0, 4'h0, 32'h0,         32'h0000_8001);
        mem_op("lh",     32'h102, 32'h0,        32'h8001_0000, 1'b1, 1'b0, 3'b001, 5'd9, 0, 4'h0, 32'h0,         32'hFFFF_8001);
        mem_op("lbu",    32'h101, 32'h0,        32'h0000_A500, 1'b1, 1'b0, 3'b100, 5'd10, 1, 4'h0, 32'h0,        32'h0000_00A5);
        mem_op("lw",     32'h300, 32'h0,        32'hCAFE_F00D, 1'b1, 1'b0, 3'b010, 5'd11, 1, 4'h0, 32'h0,        32'hCAFE_F00D);
        mem_op("l_undef",32'h310, 32'h0,        32'h1357_2468, 1'b1, 1'b0, 3'b011, 5'd12, 0, 4'h0, 32'h0,        32'h1357_2468);
        mem_op("sb",     32'h201, 32'h0000_00AB,32'h0,         1'b0, 1'b1, 3'b000, 5'd3, 1, 4'b0010, 32'hABAB_ABAB, 32'h0);
        mem_op("sh",     32'h202, 32'h1234_CDEF,32'h0,         1'b0, 1'b1, 3'b001, 5'd4, 0, 4'b1100, 32'hCDEF_CDEF, 32'h0);
        mem_op("sw",     32'h204, 32'h89AB_CDEF,32'h0,         1'b0, 1'b1, 3'b010, 5'd6, 0, 4'b1111, 32'h89AB_CDEF, 32'h0);
        mem_op("ld_st",  32'h200, 32'h0000_005A,32'hFFFF_FFFF, 1'b1, 1'b1, 3'b000, 5'd13, 0, 4'b0001, 32'h5A5A_5A5A, 32'h0);

        // Reset in the middle of an access; ack in the reset cycle and a late ack are dropped.
        drive_ex(1'b1, 32'h400, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 3'b010);
        step();
        check("rstw_dm_req_before", {31'd0, u_if.dm_req}, 32'd1);
        rst = 1'b1;
        u_if.dm_ack   = 1'b1;
        u_if.dm_rdata = 32'h7777_7777;
        step();
        check("rstw_dm_req", {31'd0, u_if.dm_req}, 32'd0);
        check("rstw_ex_ready", {31'd0, u_if.ex_ready}, 32'd1);
        check("rstw_wb_valid", {31'd0, u_if.wb_valid}, 32'd0);
        rst = 1'b0;
        u_if.ex_valid = 1'b0;
        step();
        check("late_ack_wb_valid", {31'd0, u_if.wb_valid}, 32'd0);
        check("late_ack_dm_req", {31'd0, u_if.dm_req}, 32'd0);
        u_if.dm_ack = 1'b0;
        step();
        check("late_ack_wb_valid2", {31'd0, u_if.wb_valid}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        drive_ex(1'b1, 32'h102, 32'h0, 5'd15, 1'b1, 1'b1, 1'b0, 3'b010);
        sb_q.push_back('{rd: 5'd15, we: 1'b0, data: 32'h0, chk_data: 1'b0, exc: 1'b1});
        #1;
        check("trap_dm_req_pre", {31'd0, u_if.dm_req}, 32'd0);
        step();
        u_if.ex_valid = 1'b0;
        check("trap_wb_valid", {31'd0, u_if.wb_valid}, 32'd1);
        check("trap_dm_req", {31'd0, u_if.dm_req}, 32'd0);
        check("trap_ex_ready", {31'd0, u_if.ex_ready}, 32'd1);
        step();
        check("trap_exc_clear", {31'd0, u_if.mem_exc}, 32'd0);
        check("trap_after_valid", {31'd0, u_if.wb_valid}, 32'd0);
        check("trap_dm_req_after", {31'd0, u_if.dm_req}, 32'd0);
`else
        mem_op("lw_mis", 32'h102, 32'h0, 32'h1122_3344, 1'b1, 1'b0, 3'b010, 5'd15, 0, 4'h0, 32'h0, 32'h1122_3344);
        mem_op("lh_mis", 32'h103, 32'h0, 32'h8001_0000, 1'b1, 1'b0, 3'b101, 5'd16, 0, 4'h0, 32'h0, 32'h0000_8001);
`endif

        check("final_sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, single rising-edge clock.
REQ-002 The block SHALL have port `rst`: input, 1 bit, synchronous, active-high reset.
REQ-003 The block SHALL have the following execute-side input ports:
- `ex_valid` (1): execute result present.
- `ex_c` (32): ALU result; the byte address for loads and stores.
- `ex_rs2` (32): store data.
- `ex_rd` (5): destination register.
- `ex_rwe` (1): register write enable.
- `ex_mrd` (1): load.
- `ex_mwr` (1): store.
- `ex_dmtype` (3): RV32 funct3 size/sign code.
REQ-004 The block SHALL have output `ex_ready` (1); the execute side holds its inputs while it is 0.
REQ-005 The block SHALL have the following data-memory ports:
- `dm_req` (output, 1)
- `dm_we` (output, 1)
- `dm_addr` (output, 32, word-aligned)
- `dm_be` (output, 4)
- `dm_wdata` (output, 32, lane-shifted)
- `dm_rdata` (input, 32)
- `dm_ack` (input, 1)
REQ-006 The block SHALL have the following writeback output ports:
- `wb_valid` (1)
- `wb_rd` (5)
- `wb_we` (1)
- `wb_data` (32)

Function
REQ-007 The FSM SHALL have exactly two states:
- IDLE: `ex_ready`=1.
- WAIT: `ex_ready`=0.
REQ-008 When in IDLE with `ex_valid`=1 and `ex_mrd`=`ex_mwr`=0, the block SHALL register the writeback outputs on the next edge, as follows:
- `wb_valid`=1
- `wb_data`=`ex_c`
- `wb_rd`=`ex_rd`
- `wb_we`=`ex_rwe`
This gives a latency of 1 cycle.
REQ-009 When in IDLE with `ex_valid`=1 and (`ex_mrd` or `ex_mwr`), the block SHALL latch the access on the edge and enter WAIT.
REQ-010 In WAIT, the block SHALL hold `dm_req`=1 and keep `dm_we`, `dm_addr`, `dm_be` and `dm_wdata` stable until it samples `dm_ack`=1.
REQ-011 `dm_req` SHALL be 0 in IDLE.
REQ-012 On the `dm_ack` edge, the block SHALL return to IDLE and drive `wb_valid`=1 for one cycle. The `wb_*` values SHALL be:
- Load: `wb_data` = the extended load value.
- Store: `wb_data`=0 and `wb_we`=0.
REQ-013 A load SHALL complete in a minimum of 2 cycles from acceptance, plus any `dm_ack` delay.
REQ-014 `dm_ack` SHALL be ignored in IDLE.
REQ-015 `dm_addr` SHALL equal {`ex_c`[31:2], 2'b00}.
REQ-016 The byte lane SHALL be set by `ex_c`[1:0].
REQ-017 `dm_be` SHALL be:
- SB: 4'b0001<<lane.
- SH: 4'b0011<<lane.
- SW: 4'b1111.
REQ-018 `dm_wdata` SHALL be `ex_rs2` replicated into the selected lanes (byte ×4, half ×2).
REQ-019 Loads SHALL select the lane from `dm_rdata` and extend it:
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW: pass through unchanged.
REQ-020 An undefined `ex_dmtype` SHALL be treated as word.
REQ-021 `wb_valid` SHALL be 0 in every cycle that does not complete an instruction.
REQ-022 When `ex_valid`=0 in IDLE, the block SHALL produce a bubble with `wb_valid`=0.
REQ-023 If `ex_mrd` and `ex_mwr` are both 1, the access SHALL be performed as a store.

Reset
REQ-024 When `rst`=1 on an edge, the block SHALL force IDLE from any state, including WAIT mid-access.
REQ-025 After reset, the outputs SHALL be:
- `dm_req`=0
- `wb_valid`=0
- `wb_we`=0
- `wb_data`=0
- `wb_rd`=0
REQ-026 A `dm_ack` arriving in the reset cycle SHALL be discarded.

Configuration
REQ-027 When macro `MEM_MISALIGN_TRAP_EN` is defined, the block SHALL add output `mem_exc` (1). An LH/LHU/SH with `ex_c`[0]=1, or an LW/SW with `ex_c`[1:0]≠0, SHALL:
- issue no `dm_req`;
- stay in IDLE;
- produce `wb_valid`=1, `wb_we`=0 and `mem_exc`=1 for one cycle.
REQ-028 When `MEM_MISALIGN_TRAP_EN` is undefined, the port SHALL be absent and the misaligned low address bits SHALL be cleared before the access is made.

Structure
REQ-029 The shared package SHALL hold:
- the `dmtype` constants (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101, SB/SH/SW reusing 000/001/010);
- the FSM state encoding.
REQ-030 The block SHALL contain one combinational sub-module, `load_extend`, which performs lane select and sign/zero extension.

Verification
REQ-031 Non-memory: `ex_c`=32'h0000_1234, `ex_rwe`=1, `ex_rd`=5. Next cycle: `wb_valid`=1, `wb_rd`=5, `wb_data`=32'h0000_1234, `dm_req`=0.
REQ-032 LB: `ex_c`=32'h103, `dm_rdata`=32'h80FF_0000, `dm_ack` after 3 cycles. Required: `dm_addr`=32'h100, `dm_req` high for 3 cycles, `ex_ready`=0, then `wb_data`=32'hFFFF_FF80.
REQ-033 LHU: `ex_c`=32'h102, `dm_rdata`=32'h8001_0000, `dm_ack` immediate. Required: `wb_data`=32'h0000_8001.
REQ-034 SB: `ex_c`=32'h201, `ex_rs2`=32'h0000_00AB. Required: `dm_be`=4'b0010, `dm_wdata`=32'hABAB_ABAB, `dm_we`=1, and after the ack `wb_we`=0.
REQ-035 Reset asserted in WAIT before `dm_ack`. Required: the next cycle shows `dm_req`=0, `ex_ready`=1 and `wb_valid`=0, and a late `dm_ack` is ignored.
REQ-036 With `MEM_MISALIGN_TRAP_EN`: LW at `ex_c`=32'h102. Required: `mem_exc`=1, `dm_req` never 1. Without the macro: `dm_addr`=32'h100 with a normal load.
